if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, queue entries (power of 2, >=2); RESET_PC, default 32'h0000_3000, PC after reset; ADDR_LO, default 32'h0000_3000, lowest legal fetch address; ADDR_HI, default 32'h0000_6ffc, highest legal fetch address; EXC_CODE, default 5'd4, fetch address-error code.
REQ-002 Ports SHALL be (name direction width meaning):
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
pc_branch  in  32  branch target
branch  in  1  take branch
pc_jump  in  32  j/jal target
isj  in  1  take jump
pc_jr  in  32  jr target
jr  in  1  take register jump
exc  in  1  exception redirect to 32'h0000_4180
eret  in  1  return redirect
pc_epc  in  32  eret target
out_ready  in  1  decode accepts head entry
out_valid  out  1  head entry present
out_pc  out  32  head PC
out_exp  out  1  head address-error flag
out_exccode  out  5  head exception code
out_delay  out  1  head is a delay-slot instruction
count  out  $clog2(DEPTH)+1  occupied entries
REQ-003 Clock port SHALL be clk and reset port reset; reset is synchronous and active-high.

Function
REQ-004 Block SHALL hold a fetch PC register and a circular FIFO of DEPTH entries {pc, exp, exccode, delay} with read/write pointers wrapping modulo DEPTH.
REQ-005 Outputs SHALL reflect the head entry combinationally; out_valid = (count != 0); head fields SHALL be 0 when empty.
REQ-006 Dequeue SHALL occur iff out_valid && out_ready.
REQ-007 Enqueue SHALL occur in a cycle iff state is RUN and (count < DEPTH or dequeue occurs that cycle); enqueued pc = fetch PC; fetch PC then += 4.
REQ-008 exp SHALL be 1 iff pc[1:0] != 0 or pc < ADDR_LO or pc > ADDR_HI (unsigned); exccode = EXC_CODE when exp, else 0.
REQ-009 State machine: RUN (fetching) and HALT (no enqueue); RUN->HALT when an entry with exp=1 is enqueued; HALT->RUN only on a redirect.
REQ-010 Redirect priority SHALL be exc > eret > jr > isj > branch; one redirect per cycle, lower ones ignored; targets 32'h0000_4180, pc_epc, pc_jr, pc_jump, pc_branch.
REQ-011 exc or eret SHALL flush all entries (including any not-yet-dequeued head), load fetch PC with target, enter RUN; no enqueue that cycle.
REQ-012 jr/isj/branch (control redirect) SHALL preserve the delay slot: dequeue of the branching instruction is applied first; if ≥1 entry remains, the oldest remaining entry is kept with delay=1 and all younger entries flushed; if none remains, fetch PC is enqueued that cycle with delay=1 (regardless of HALT, exp computed per REQ-008); fetch PC <= target; state <= RUN, or HALT if the delay-slot entry enqueued has exp=1.
REQ-013 Non-redirect enqueues SHALL have delay=0.
REQ-014 count SHALL equal enqueues minus dequeues minus flushed entries, never exceed DEPTH, never underflow.
REQ-015 Full (count==DEPTH) with no dequeue SHALL stall fetch PC unchanged; simultaneous dequeue+enqueue at full SHALL keep count==DEPTH.
REQ-016 Fetch PC arithmetic SHALL be 32-bit wrap-around; wrap produces exp=1 entries, no special handling.

Reset
REQ-017 On reset: fetch PC = RESET_PC, pointers = 0, count = 0, state = RUN, all outputs 0; reset overrides redirects and handshakes in the same cycle.
REQ-018 Reset asserted mid-operation SHALL discard all entries at the next edge; first enqueue (pc = RESET_PC) occurs in the first cycle with reset low.

Verification
REQ-019 Reset, out_ready=0 for 6 cycles -> entries 3000,3004,3008,300c; count=4; fetch PC holds 3010.
REQ-020 Full queue, out_ready=1 continuously -> one entry per cycle, count stays 4, out_pc sequence 3000,3004,3008,...
REQ-021 count=3 (3000,3004,3008), head 3000 dequeued with branch=1 pc_branch=3100 -> 3004 kept delay=1, 3008 flushed, next entries 3100,3104; count=1 after edge.
REQ-022 count=0, fetch PC 3020, isj=1 pc_jump=3200 -> entry 3020 delay=1 enqueued, next entry 3200 delay=0.
REQ-023 jr=1 pc_jr=3002 -> entry 3002 exp=1 exccode=4, state HALT, no further enqueue; exc=1 -> queue flushed, next entry 4180 exp=0.
REQ-024 exc=1 and branch=1 same cycle with 3 entries -> all flushed, count=0, next entry 4180 delay=0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch PC generator feeding a circular queue; head fields are combinational (0 cycles), entries land one edge after fetch.
// Backpressure: fetch stalls with PC held while the queue is full and decode does not dequeue; HALT stops fetch after an address error.
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] ADDR_LO  = 32'h0000_3000,
    parameter logic [31:0] ADDR_HI  = 32'h0000_6ffc,
    parameter logic [4:0]  EXC_CODE = 5'd4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc_branch,
    input  logic                     branch,
    input  logic [31:0]              pc_jump,
    input  logic                     isj,
    input  logic [31:0]              pc_jr,
    input  logic                     jr,
    input  logic                     exc,
    input  logic                     eret,
    input  logic [31:0]              pc_epc,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic                     out_exp,
    output logic [4:0]               out_exccode,
    output logic                     out_delay,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [31:0] EXC_VEC = 32'h0000_4180;

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        exp;
        logic [4:0]  exccode;
        logic        delay;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    entry_t          wr_dat;
    logic [PW-1:0]   rd_ptr, wr_ptr, rd_adv;
    logic [PW-1:0]   rd_nxt, wr_nxt;
    logic [PW:0]     remain, cnt_nxt;
    logic [31:0]     fpc, fpc_nxt;
    state_t          state, state_nxt;
    logic            deq, fetch_exp, wr_en, mark_en;

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_pc      = out_valid ? head.pc      : 32'd0;
    assign out_exp     = out_valid ? head.exp     : 1'b0;
    assign out_exccode = out_valid ? head.exccode : 5'd0;
    assign out_delay   = out_valid ? head.delay   : 1'b0;

    assign deq       = out_valid && out_ready;
    assign rd_adv    = rd_ptr + PW'(deq);
    assign remain    = count - (PW+1)'(deq);
    assign fetch_exp = (fpc[1:0] != 2'b00) || (fpc < ADDR_LO) || (fpc > ADDR_HI);

    always_comb begin
        fpc_nxt        = fpc;
        rd_nxt         = rd_adv;
        wr_nxt         = wr_ptr;
        cnt_nxt        = remain;
        state_nxt      = state;
        wr_en          = 1'b0;
        mark_en        = 1'b0;
        wr_dat.pc      = fpc;
        wr_dat.exp     = fetch_exp;
        wr_dat.exccode = fetch_exp ? EXC_CODE : 5'd0;
        wr_dat.delay   = 1'b0;

        if (exc || eret) begin
            fpc_nxt   = exc ? EXC_VEC : pc_epc;
            rd_nxt    = '0;
            wr_nxt    = '0;
            cnt_nxt   = '0;
            state_nxt = RUN;
        end else if (jr || isj || branch) begin
            fpc_nxt = jr ? pc_jr : (isj ? pc_jump : pc_branch);
            cnt_nxt = (PW+1)'(1);
            wr_nxt  = rd_adv + PW'(1);
            if (remain != '0) begin
                // Oldest surviving entry becomes the delay slot; everything younger is dropped.
                mark_en   = 1'b1;
                state_nxt = RUN;
            end else begin
                // Nothing left to serve as delay slot: fetch it now, even from HALT.
                wr_en        = 1'b1;
                wr_dat.delay = 1'b1;
                state_nxt    = fetch_exp ? HALT : RUN;
            end
        end else if (state == RUN && (count < (PW+1)'(DEPTH) || deq)) begin
            wr_en   = 1'b1;
            wr_nxt  = wr_ptr + PW'(1);
            cnt_nxt = remain + (PW+1)'(1);
            fpc_nxt = fpc + 32'd4;
            if (fetch_exp)
                state_nxt = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc    <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            fpc    <= fpc_nxt;
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_nxt;
            count  <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_en)
                mem[wr_ptr] <= wr_dat;
            if (mark_en)
                mem[rd_adv].delay <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: cycle table for reset/fill/stream/redirect, then scoreboarded sequences for delay-slot, HALT and range corners.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_branch = '0, pc_jump = '0, pc_jr = '0, pc_epc = '0;
    logic        branch = 1'b0, isj = 1'b0, jr = 1'b0, exc = 1'b0, eret = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_exp, out_delay;
    logic [31:0] out_pc;
    logic [4:0]  out_exccode;
    logic [2:0]  count;

    int errs = 0;
    int checks = 0;

    if_fetch_queue dut (
        .clk(clk), .reset(reset),
        .pc_branch(pc_branch), .branch(branch),
        .pc_jump(pc_jump), .isj(isj),
        .pc_jr(pc_jr), .jr(jr),
        .exc(exc), .eret(eret), .pc_epc(pc_epc),
        .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_exp(out_exp), .out_exccode(out_exccode), .out_delay(out_delay),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, rdy, br, ex;
        logic [31:0] tgt;
        logic        v;
        logic [31:0] pc;
        logic        d;
        logic [2:0]  cnt;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        e;
        logic [4:0]  c;
        logic        d;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    logic sb_on = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic void add(logic rst, logic rdy, logic br, logic ex, logic [31:0] tgt,
                                logic v, logic [31:0] pc, logic d, logic [2:0] cnt);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.br = br; r.ex = ex; r.tgt = tgt;
        r.v = v; r.pc = pc; r.d = d; r.cnt = cnt;
        tbl.push_back(r);
    endfunction

    function automatic void push(logic [31:0] pc, logic e, logic d);
        exp_t x;
        x.pc = pc; x.e = e; x.c = e ? 5'd4 : 5'd0; x.d = d;
        sb.push_back(x);
    endfunction

    always @(negedge clk) begin
        if (sb_on && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL sb_unexpected: got pc %0h, nothing expected", out_pc);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check($sformatf("sb_entry_%0h", x.pc),
                      {25'd0, out_pc, out_exp, out_exccode, out_delay},
                      {25'd0, x.pc, x.e, x.c, x.d});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        branch = 1'b0; isj = 1'b0; jr = 1'b0; exc = 1'b0; eret = 1'b0;
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b1; out_ready = 1'b0; idle();
        cyc();
        reset = 1'b0;
    endtask

    task automatic sb_empty(string name);
        check(name, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        //  rst rdy br ex  tgt             v  pc              d  cnt
        add(1, 0, 0, 0, 32'h0,          0, 32'h0,          0, 3'd0);
        add(1, 1, 0, 1, 32'h0,          0, 32'h0,          0, 3'd0);
        add(0, 0, 0, 0, 32'h0,          0, 32'h0,          0, 3'd0);
        add(0, 0, 0, 0, 32'h0,          1, 32'h0000_3000,  0, 3'd1);
        add(0, 0, 0, 0, 32'h0,          1, 32'h0000_3000,  0, 3'd2);
        add(0, 0, 0, 0, 32'h0,          1, 32'h0000_3000,  0, 3'd3);
        add(0, 0, 0, 0, 32'h0,          1, 32'h0000_3000,  0, 3'd4);
        add(0, 0, 0, 0, 32'h0,          1, 32'h0000_3000,  0, 3'd4);
        add(0, 1, 0, 0, 32'h0,          1, 32'h0000_3000,  0, 3'd4);
        add(0, 1, 0, 0, 32'h0,          1, 32'h0000_3004,  0, 3'd4);
        add(0, 0, 0, 0, 32'h0,          1, 32'h0000_3008,  0, 3'd4);
        add(0, 1, 1, 0, 32'h0000_3100,  1, 32'h0000_3008,  0, 3'd4);
        add(0, 0, 0, 0, 32'h0,          1, 32'h0000_300c,  1, 3'd1);
        add(0, 1, 0, 0, 32'h0,          1, 32'h0000_300c,  1, 3'd2);
        add(0, 1, 0, 0, 32'h0,          1, 32'h0000_3100,  0, 3'd2);
        add(0, 1, 1, 1, 32'h0000_3100,  1, 32'h0000_3104,  0, 3'd2);
        add(0, 1, 0, 0, 32'h0,          0, 32'h0,          0, 3'd0);
        add(0, 0, 0, 0, 32'h0,          1, 32'h0000_4180,  0, 3'd1);
        add(0, 0, 0, 0, 32'h0,          1, 32'h0000_4180,  0, 3'd2);

        foreach (tbl[i]) begin
            cyc();
            reset = tbl[i].rst; out_ready = tbl[i].rdy;
            branch = tbl[i].br; exc = tbl[i].ex;
            pc_branch = tbl[i].tgt; pc_jump = tbl[i].tgt; pc_jr = tbl[i].tgt; pc_epc = tbl[i].tgt;
            @(negedge clk);
            check($sformatf("v%0d_valid", i), 64'(out_valid), 64'(tbl[i].v));
            check($sformatf("v%0d_pc", i),    64'(out_pc),    64'(tbl[i].pc));
            check($sformatf("v%0d_exp", i),   64'(out_exp),   64'd0);
            check($sformatf("v%0d_delay", i), 64'(out_delay), 64'(tbl[i].d));
            check($sformatf("v%0d_count", i), 64'(count),     64'(tbl[i].cnt));
        end

        sb_on = 1'b1;

        // Fill for six cycles, then stream with continuous ready.
        do_reset();
        repeat (6) cyc();
        check("fill_count", 64'(count), 64'd4);
        for (int k = 0; k < 20; k++) push(32'h0000_3000 + 32'(4 * k), 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            check($sformatf("stream_count_%0d", k), 64'(count), 64'd4);
        end
        out_ready = 1'b0;
        sb_empty("stream_drained");

        // Branch dequeued from a 3-deep queue keeps the next entry as delay slot.
        do_reset();
        repeat (3) cyc();
        check("br_pre_count", 64'(count), 64'd3);
        out_ready = 1'b1; branch = 1'b1; pc_branch = 32'h0000_3100;
        push(32'h0000_3000, 0, 0); push(32'h0000_3004, 0, 1);
        push(32'h0000_3100, 0, 0); push(32'h0000_3104, 0, 0);
        cyc();
        idle();
        check("br_post_count", 64'(count), 64'd1);
        repeat (3) cyc();
        out_ready = 1'b0;
        sb_empty("br_drained");

        // Eret to 3020, then a jump on an empty queue fetches the delay slot itself.
        do_reset();
        repeat (2) cyc();
        eret = 1'b1; pc_epc = 32'h0000_3020;
        cyc();
        idle();
        check("eret_flush_count", 64'(count), 64'd0);
        check("eret_flush_valid", 64'(out_valid), 64'd0);
        isj = 1'b1; pc_jump = 32'h0000_3200;
        push(32'h0000_3020, 0, 1); push(32'h0000_3200, 0, 0);
        cyc();
        idle();
        check("j_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        repeat (2) cyc();
        out_ready = 1'b0;
        sb_empty("j_drained");

        // Misaligned jr target halts fetch; exc restarts at the vector.
        do_reset();
        jr = 1'b1; pc_jr = 32'h0000_3002;
        push(32'h0000_3000, 0, 1); push(32'h0000_3002, 1, 0);
        cyc();
        idle();
        repeat (4) cyc();
        check("halt_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        repeat (2) cyc();
        out_ready = 1'b0;
        check("halt_empty", 64'(count), 64'd0);
        cyc();
        check("halt_stays_empty", 64'(count), 64'd0);
        exc = 1'b1;
        push(32'h0000_4180, 0, 0);
        cyc();
        idle();
        cyc();
        check("exc_refetch_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        sb_empty("halt_drained");

        // exc beats a simultaneous branch and flushes three entries.
        do_reset();
        repeat (3) cyc();
        exc = 1'b1; branch = 1'b1; pc_branch = 32'h0000_3100;
        push(32'h0000_4180, 0, 0);
        cyc();
        idle();
        check("excbr_count", 64'(count), 64'd0);
        cyc();
        check("excbr_refill", 64'(count), 64'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        sb_empty("excbr_drained");

        // Reset mid-operation overrides redirects.
        do_reset();
        repeat (3) cyc();
        reset = 1'b1; exc = 1'b1; isj = 1'b1; pc_jump = 32'h0000_3200;
        cyc();
        check("rst_mid_count", 64'(count), 64'd0);
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_pc", 64'(out_pc), 64'd0);
        reset = 1'b0; idle();
        push(32'h0000_3000, 0, 0);
        cyc();
        check("rst_first_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        sb_empty("rst_drained");

        // Upper and lower legal-address boundaries.
        do_reset();
        eret = 1'b1; pc_epc = 32'h0000_6ffc;
        push(32'h0000_6ffc, 0, 0); push(32'h0000_7000, 1, 0);
        cyc();
        idle();
        repeat (4) cyc();
        check("hi_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        repeat (2) cyc();
        out_ready = 1'b0;
        eret = 1'b1; pc_epc = 32'h0000_2ffc;
        push(32'h0000_2ffc, 1, 0);
        cyc();
        idle();
        repeat (3) cyc();
        check("lo_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        sb_empty("range_drained");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
